// File: rtl/irq_timer_ctrl_pkg.sv
// irq_timer_ctrl_pkg
//   Shared constants for the MC6809 interrupt controller / interval timer.
//   - Register indices inside the 8-byte CPU window (addr[2:0]).
//   - Bit positions inside the CTRL register.
//   - Number of cycles the external-source synchronizer needs after reset
//     before its edge history holds real samples.
package irq_timer_ctrl_pkg;

    localparam logic [2:0] REG_PEND   = 3'd0;
    localparam logic [2:0] REG_MASK   = 3'd1;
    localparam logic [2:0] REG_ROUTE  = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_RLD_HI = 3'd4;
    localparam logic [2:0] REG_RLD_LO = 3'd5;
    localparam logic [2:0] REG_CNT_HI = 3'd6;
    localparam logic [2:0] REG_CNT_LO = 3'd7;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;

    // sync1 -> sync2 -> hist takes three edges to fill with real samples
    localparam logic [1:0] SYNC_PRIMED = 2'd3;

endpackage

// File: rtl/irq_prescale_timer.sv
// irq_prescale_timer
//   Prescaler plus 16-bit down counter with auto-reload and one-shot stop.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     en         timer run enable (CTRL.EN)
//     oneshot    CTRL.ONESHOT; raises stop together with expire
//     reload     16-bit reload value
//     load       CPU write to RLD_LO: count <= load_val, prescaler cleared
//     load_val   value loaded into count by load
//     hold       CPU write to CTRL: discards this edge's decrement/reload
//     count      live counter value
//     expire     1-cycle pulse: tick seen while count == 0
//     stop       expire in one-shot mode; owner of EN clears it
module irq_prescale_timer
    import irq_timer_ctrl_pkg::*;
#(
    parameter int PRESCALE = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        oneshot,
    input  logic [15:0] reload,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        hold,
    output logic [15:0] count,
    output logic        expire,
    output logic        stop
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;
    logic          tick;

    // With PRESCALE == 1 presc is stuck at 0 == PMAX and ticks every cycle.
    assign tick   = en && (presc == PMAX);
    assign expire = tick && (count == 16'd0);
    assign stop   = expire && oneshot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (load || !en || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // A CPU load/CTRL write on a tick edge wins over the tick; expire is
    // still raised so the pending bit is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 16'd0;
        end else if (load) begin
            count <= load_val;
        end else if (hold) begin
            count <= count;
        end else if (tick) begin
            count <= (count == 16'd0) ? reload : count - 16'd1;
        end
    end

endmodule

// File: rtl/irq_timer_ctrl.sv
// irq_timer_ctrl
//   Memory-mapped interrupt controller and interval timer for the MC6809 bus.
//   Pending bit 0 is the timer, bits NSRC:1 are external rising-edge sources.
//   Each enabled pending bit is routed to IRQ (route=0) or FIRQ (route=1).
//   Ports:
//     cpu_clk, cpu_reset  clock, asynchronous active-high reset
//     cs_i, addr_i        window select and register index
//     oe_i, we_i          CPU read / write strobes
//     data_i, data_o      write data / combinational read data (0 unless cs&oe)
//     src_i               external interrupt lines, asynchronous to cpu_clk
//     irq_n_o, firq_n_o   registered active-low interrupt requests
module irq_timer_ctrl
    import irq_timer_ctrl_pkg::*;
#(
    parameter int NSRC     = 3,
    parameter int PRESCALE = 40
) (
    input  logic            cpu_clk,
    input  logic            cpu_reset,
    input  logic            cs_i,
    input  logic [2:0]      addr_i,
    input  logic            oe_i,
    input  logic            we_i,
    input  logic [7:0]      data_i,
    output logic [7:0]      data_o,
    input  logic [NSRC-1:0] src_i,
    output logic            irq_n_o,
    output logic            firq_n_o
);

    localparam int NB = NSRC + 1;

    logic            wr, rd;
    logic            wr_pend, wr_mask, wr_route, wr_ctrl, wr_rld_hi, wr_rld_lo;
    logic            rd_cnt_hi;

    logic [NB-1:0]   pending, mask, route;
    logic [NB-1:0]   pend_set, pend_clr;
    logic            en, oneshot;
    logic [15:0]     reload;
    logic [7:0]      shadow;
    logic [7:0]      rdata;

    logic [NSRC-1:0] sync1, sync2, hist, src_rise;
    logic [1:0]      prime;

    logic [15:0]     count;
    logic            expire, stop;

    assign wr = cs_i & we_i;
    assign rd = cs_i & oe_i;

    assign wr_pend   = wr && (addr_i == REG_PEND);
    assign wr_mask   = wr && (addr_i == REG_MASK);
    assign wr_route  = wr && (addr_i == REG_ROUTE);
    assign wr_ctrl   = wr && (addr_i == REG_CTRL);
    assign wr_rld_hi = wr && (addr_i == REG_RLD_HI);
    assign wr_rld_lo = wr && (addr_i == REG_RLD_LO);
    assign rd_cnt_hi = rd && (addr_i == REG_CNT_HI);

    // ------------------------------------------------------------------
    // External sources: two-flop synchronizer plus edge history.
    // After reset the chain holds zeros, which would make a line that is
    // already high look like a fresh rising edge.  Edge detection stays
    // off until the chain has been refilled from real samples, so only a
    // genuine low->high transition after that can raise a pending bit.
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
            prime <= 2'd0;
        end else begin
            sync1 <= src_i;
            sync2 <= sync1;
            hist  <= sync2;
            if (prime != SYNC_PRIMED) begin
                prime <= prime + 2'd1;
            end
        end
    end

    assign src_rise = (prime == SYNC_PRIMED) ? (sync2 & ~hist) : '0;

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
    irq_prescale_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk      (cpu_clk),
        .rst      (cpu_reset),
        .en       (en),
        .oneshot  (oneshot),
        .reload   (reload),
        .load     (wr_rld_lo),
        .load_val ({reload[15:8], data_i}),
        .hold     (wr_ctrl),
        .count    (count),
        .expire   (expire),
        .stop     (stop)
    );

    // ------------------------------------------------------------------
    // Pending: hardware set beats software 1-to-clear in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        pend_clr = '0;
        if (wr_pend) begin
            pend_clr = data_i[NB-1:0];
        end
        pend_set = {src_rise, expire};
    end

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~pend_clr) | pend_set;
        end
    end

    // ------------------------------------------------------------------
    // CPU-visible control registers
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            mask    <= '0;
            route   <= '0;
            en      <= 1'b0;
            oneshot <= 1'b0;
            reload  <= 16'd0;
            shadow  <= 8'd0;
        end else begin
            if (wr_mask) begin
                mask <= data_i[NB-1:0];
            end
            if (wr_route) begin
                route <= data_i[NB-1:0];
            end
            // A CTRL write on the expiry edge keeps the value written,
            // overriding the one-shot stop.
            if (wr_ctrl) begin
                en      <= data_i[CTRL_EN];
                oneshot <= data_i[CTRL_ONESHOT];
            end else if (stop) begin
                en <= 1'b0;
            end
            if (wr_rld_hi) begin
                reload[15:8] <= data_i;
            end
            if (wr_rld_lo) begin
                reload[7:0] <= data_i;
            end
            // Reading CNT_HI freezes the low byte so CNT_LO reads coherently.
            if (rd_cnt_hi) begin
                shadow <= count[7:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Interrupt outputs, registered one cycle behind pending/mask/route.
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            irq_n_o  <= 1'b1;
            firq_n_o <= 1'b1;
        end else begin
            irq_n_o  <= ~|(pending & mask & ~route);
            firq_n_o <= ~|(pending & mask & route);
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rdata = 8'h00;
        if (rd) begin
            case (addr_i)
                REG_PEND:   rdata = 8'(pending);
                REG_MASK:   rdata = 8'(mask);
                REG_ROUTE:  rdata = 8'(route);
                REG_CTRL: begin
                    rdata[CTRL_EN]      = en;
                    rdata[CTRL_ONESHOT] = oneshot;
                end
                REG_RLD_HI: rdata = reload[15:8];
                REG_RLD_LO: rdata = reload[7:0];
                REG_CNT_HI: rdata = count[15:8];
                REG_CNT_LO: rdata = shadow;
                default:    rdata = 8'h00;
            endcase
        end
    end

    assign data_o = rdata;

endmodule

// File: tb/tb_irq_timer_ctrl.sv
module tb_irq_timer_ctrl;

    localparam int NSRC     = 3;
    localparam int PRESCALE = 4;
    localparam int NB       = NSRC + 1;
    localparam int ALL      = (1 << NB) - 1;

    logic            cpu_clk = 1'b0;
    logic            cpu_reset;
    logic            cs_i, oe_i, we_i;
    logic [2:0]      addr_i;
    logic [7:0]      data_i;
    logic [7:0]      data_o;
    logic [NSRC-1:0] src_i;
    logic            irq_n_o, firq_n_o;

    int checks = 0;
    int errors = 0;

    irq_timer_ctrl #(.NSRC(NSRC), .PRESCALE(PRESCALE)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_reset (cpu_reset),
        .cs_i      (cs_i),
        .addr_i    (addr_i),
        .oe_i      (oe_i),
        .we_i      (we_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .src_i     (src_i),
        .irq_n_o   (irq_n_o),
        .firq_n_o  (firq_n_o)
    );

    always #5 cpu_clk = ~cpu_clk;

    // ---------------- behavioural reference model ----------------
    // Timer phase is kept as "edges left until the next tick"; external
    // sources as a plain delay line of the values sampled at each edge.
    int m_pend, m_mask, m_route, m_en, m_os, m_reload, m_count, m_shadow;
    int m_tleft, m_irq_n, m_firq_n, m_since, p1, p2, p3;

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_route = 0; m_en = 0; m_os = 0;
        m_reload = 0; m_count = 0; m_shadow = 0; m_tleft = PRESCALE;
        m_irq_n = 1; m_firq_n = 1; m_since = 0; p1 = 0; p2 = 0; p3 = 0;
    endtask

    function automatic int model_read(int a);
        case (a)
            0: return m_pend;
            1: return m_mask;
            2: return m_route;
            3: return (m_os << 1) | m_en;
            4: return m_reload >> 8;
            5: return m_reload & 'hFF;
            6: return m_count >> 8;
            default: return m_shadow;
        endcase
    endfunction

    // Advance one clock edge: DUT and model together.
    task automatic step();
        int a, d, wr, rd, tick, expire, rise, clr, sv;
        int n_pend, n_mask, n_route, n_reload, n_count, n_en, n_os;
        int n_tleft, n_shadow, n_irq, n_firq;
        if (cpu_reset) begin
            @(posedge cpu_clk);
            #1;
        end else begin
            a = int'(addr_i); d = int'(data_i); sv = int'(src_i);
            wr = (cs_i && we_i) ? 1 : 0;
            rd = (cs_i && oe_i) ? 1 : 0;
            tick   = (m_en == 1 && m_tleft == 1) ? 1 : 0;
            expire = (tick == 1 && m_count == 0) ? 1 : 0;
            rise   = (m_since >= 3) ? (p2 & ~p3) : 0;
            clr    = (wr == 1 && a == 0) ? (d & ALL) : 0;
            n_pend = ((m_pend & ~clr) | (rise << 1) | expire) & ALL;
            n_irq  = ((m_pend & m_mask & ~m_route) == 0) ? 1 : 0;
            n_firq = ((m_pend & m_mask & m_route) == 0) ? 1 : 0;
            n_mask  = (wr == 1 && a == 1) ? (d & ALL) : m_mask;
            n_route = (wr == 1 && a == 2) ? (d & ALL) : m_route;
            n_reload = m_reload;
            if (wr == 1 && a == 4) n_reload = (d << 8) | (m_reload & 'hFF);
            if (wr == 1 && a == 5) n_reload = (m_reload & 'hFF00) | d;
            n_count = m_count;
            if (wr == 1 && a == 5)      n_count = (m_reload & 'hFF00) | d;
            else if (wr == 1 && a == 3) n_count = m_count;
            else if (tick == 1)         n_count = (m_count == 0) ? m_reload : m_count - 1;
            n_en = m_en; n_os = m_os;
            if (wr == 1 && a == 3) begin
                n_en = d & 1; n_os = (d >> 1) & 1;
            end else if (expire == 1 && m_os == 1) begin
                n_en = 0;
            end
            if (m_en == 0 || (wr == 1 && a == 5) || tick == 1) n_tleft = PRESCALE;
            else n_tleft = m_tleft - 1;
            n_shadow = (rd == 1 && a == 6) ? (m_count & 'hFF) : m_shadow;
            @(posedge cpu_clk);
            m_pend = n_pend; m_mask = n_mask; m_route = n_route;
            m_reload = n_reload; m_count = n_count; m_en = n_en; m_os = n_os;
            m_tleft = n_tleft; m_shadow = n_shadow; m_irq_n = n_irq; m_firq_n = n_firq;
            p3 = p2; p2 = p1; p1 = sv;
            if (m_since < 3) m_since = m_since + 1;
            #1;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        cs_i = 1'b0; we_i = 1'b0; oe_i = 1'b0; addr_i = 3'd0; data_i = 8'h00;
    endtask

    task automatic write(input int a, input int d);
        cs_i = 1'b1; we_i = 1'b1; oe_i = 1'b0; addr_i = 3'(a); data_i = 8'(d);
        step();
        idle();
    endtask

    task automatic drive_read(input int a);
        cs_i = 1'b1; we_i = 1'b0; oe_i = 1'b1; addr_i = 3'(a); data_i = 8'h00;
        #1;
    endtask

    task automatic do_reset();
        idle();
        cpu_reset = 1'b1;
        model_reset();
        #1;
        step(); step();
        cpu_reset = 1'b0;
        step(); step(); step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (irq_n_o !== 1'b1 || firq_n_o !== 1'b1) begin
            errors++; $display("FAIL reset_outputs: irq_n=%b firq_n=%b, want 1 1", irq_n_o, firq_n_o);
        end
        for (int a = 0; a < 8; a++) begin
            drive_read(a);
            checks++;
            if (data_o !== 8'h00) begin
                errors++; $display("FAIL reset_reg%0d: got %h want 00", a, data_o);
            end
            step();
            idle();
        end
        checks++;
        if (data_o !== 8'h00) begin
            errors++; $display("FAIL idle_bus: got %h want 00", data_o);
        end
    endtask

    task automatic test_periodic();
        do_reset();
        write(1, 8'h01); write(4, 0); write(5, 2); write(3, 8'h01);   // CTRL at E0
        for (int i = 1; i <= 11; i++) begin
            step();
            checks++;
            if (irq_n_o !== 1'b1) begin
                errors++; $display("FAIL periodic_early: cycle %0d irq_n=%b want 1", i, irq_n_o);
            end
        end
        step();                                                        // E12
        drive_read(0);
        checks++;
        if (data_o !== 8'h01) begin
            errors++; $display("FAIL periodic_pend: got %h want 01", data_o);
        end
        idle();
        step();                                                        // E13
        checks++;
        if (irq_n_o !== 1'b0 || firq_n_o !== 1'b1) begin
            errors++; $display("FAIL periodic_irq: irq_n=%b firq_n=%b want 0 1", irq_n_o, firq_n_o);
        end
        write(0, 8'h01);                                               // E14
        step();                                                        // E15
        checks++;
        if (irq_n_o !== 1'b1) begin
            errors++; $display("FAIL periodic_clear: irq_n=%b want 1", irq_n_o);
        end
        for (int i = 16; i <= 24; i++) begin
            step();
            checks++;
            if (irq_n_o !== 1'b1 || irq_n_o !== 1'(m_irq_n)) begin
                errors++; $display("FAIL periodic_gap: cycle %0d irq_n=%b want 1", i, irq_n_o);
            end
        end
        step();                                                        // E25
        checks++;
        if (irq_n_o !== 1'b0) begin
            errors++; $display("FAIL periodic_second: irq_n=%b want 0", irq_n_o);
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        write(1, 8'h01); write(4, 0); write(5, 2); write(3, 8'h03);
        for (int i = 1; i <= 12; i++) step();
        drive_read(3);
        checks++;
        if (data_o !== 8'h02) begin
            errors++; $display("FAIL oneshot_ctrl: got %h want 02", data_o);
        end
        idle();
        for (int i = 0; i < 30; i++) step();
        drive_read(6);
        checks++;
        if (data_o !== 8'h00) begin
            errors++; $display("FAIL oneshot_cnt_hi: got %h want 00", data_o);
        end
        step();
        drive_read(7);
        checks++;
        if (data_o !== 8'h02) begin
            errors++; $display("FAIL oneshot_cnt_lo: got %h want 02", data_o);
        end
        drive_read(0);
        checks++;
        if (data_o !== 8'h01 || irq_n_o !== 1'b0) begin
            errors++; $display("FAIL oneshot_single: pend=%h irq_n=%b want 01 0", data_o, irq_n_o);
        end
        idle();
    endtask

    task automatic test_external();
        do_reset();
        write(1, 8'h02); write(2, 8'h02);
        src_i = 3'b001;
        step(); step();
        drive_read(0);
        checks++;
        if (data_o !== 8'h00) begin
            errors++; $display("FAIL ext_early: pend=%h want 00", data_o);
        end
        idle();
        step();
        drive_read(0);
        checks++;
        if (data_o !== 8'h02) begin
            errors++; $display("FAIL ext_pend: pend=%h want 02", data_o);
        end
        idle();
        step();
        checks++;
        if (firq_n_o !== 1'b0 || irq_n_o !== 1'b1) begin
            errors++; $display("FAIL ext_firq: firq_n=%b irq_n=%b want 0 1", firq_n_o, irq_n_o);
        end
        write(0, 8'h02);
        for (int i = 0; i < 10; i++) step();
        drive_read(0);
        checks++;
        if (data_o !== 8'h00 || firq_n_o !== 1'b1) begin
            errors++; $display("FAIL ext_no_retrigger: pend=%h firq_n=%b want 00 1", data_o, firq_n_o);
        end
        idle();
        src_i = 3'b000;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_collision();
        do_reset();
        write(1, 8'h01); write(4, 0); write(5, 2); write(3, 8'h01);
        for (int i = 1; i <= 11; i++) step();
        write(0, 8'h01);                                               // same edge as expiry
        drive_read(0);
        checks++;
        if (data_o !== 8'h01) begin
            errors++; $display("FAIL collision_pend: got %h want 01", data_o);
        end
        idle();
    endtask

    task automatic test_atomic();
        do_reset();
        write(4, 8'h01); write(5, 8'h00); write(3, 8'h01);
        step(); step(); step();
        drive_read(6);
        checks++;
        if (data_o !== 8'h01) begin
            errors++; $display("FAIL atomic_hi: got %h want 01", data_o);
        end
        step();                                                        // tick: 0100 -> 00FF
        drive_read(7);
        checks++;
        if (data_o !== 8'h00) begin
            errors++; $display("FAIL atomic_lo: got %h want 00", data_o);
        end
        drive_read(6);
        checks++;
        if (data_o !== 8'h00) begin
            errors++; $display("FAIL atomic_live_hi: got %h want 00", data_o);
        end
        step();
        drive_read(7);
        checks++;
        if (data_o !== 8'hFF) begin
            errors++; $display("FAIL atomic_lo2: got %h want ff", data_o);
        end
        idle();
    endtask

    task automatic test_reset_src_high();
        do_reset();
        write(1, 8'h0E);
        src_i = 3'b111;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (irq_n_o !== 1'b0) begin
            errors++; $display("FAIL rst_src_setup: irq_n=%b want 0", irq_n_o);
        end
        cpu_reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (irq_n_o !== 1'b1 || firq_n_o !== 1'b1) begin
            errors++; $display("FAIL rst_async: irq_n=%b firq_n=%b want 1 1", irq_n_o, firq_n_o);
        end
        step(); step();
        cpu_reset = 1'b0;
        write(1, 8'h0E);
        for (int i = 0; i < 10; i++) step();
        drive_read(0);
        checks++;
        if (data_o !== 8'h00 || irq_n_o !== 1'b1) begin
            errors++; $display("FAIL rst_src_high: pend=%h irq_n=%b want 00 1", data_o, irq_n_o);
        end
        idle();
        src_i = 3'b000;
        for (int i = 0; i < 4; i++) step();
        src_i = 3'b010;
        for (int i = 0; i < 3; i++) step();
        drive_read(0);
        checks++;
        if (data_o !== 8'h04) begin
            errors++; $display("FAIL rst_src_rerise: pend=%h want 04", data_o);
        end
        idle();
        src_i = 3'b000;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_random();
        int exp_d;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            cs_i   = ($urandom_range(0, 99) < 60);
            we_i   = 1'($urandom_range(0, 1));
            oe_i   = 1'($urandom_range(0, 1));
            addr_i = 3'($urandom_range(0, 7));
            data_i = 8'($urandom);
            if (addr_i == 3'd3) data_i = {6'd0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0)};
            if (addr_i == 3'd4) data_i = ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00;
            if (addr_i == 3'd5) data_i = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 14) == 0) src_i = src_i ^ NSRC'(1 << $urandom_range(0, NSRC - 1));
            #1;
            exp_d = (cs_i && oe_i) ? model_read(int'(addr_i)) : 0;
            checks++;
            if (data_o !== 8'(exp_d)) begin
                errors++; $display("FAIL rand_rdata: n=%0d addr=%0d got %h want %h", n, addr_i, data_o, 8'(exp_d));
            end
            checks++;
            if (irq_n_o !== 1'(m_irq_n) || firq_n_o !== 1'(m_firq_n)) begin
                errors++; $display("FAIL rand_irq: n=%0d irq_n=%b firq_n=%b want %0d %0d", n, irq_n_o, firq_n_o, m_irq_n, m_firq_n);
            end
            if ($urandom_range(0, 799) == 0) begin
                cpu_reset = 1'b1;
                model_reset();
                #1;
                checks++;
                if (irq_n_o !== 1'b1 || firq_n_o !== 1'b1) begin
                    errors++; $display("FAIL rand_reset: irq_n=%b firq_n=%b want 1 1", irq_n_o, firq_n_o);
                end
                idle();
                step();
                cpu_reset = 1'b0;
            end else begin
                step();
            end
        end
        idle();
    endtask

    initial begin
        cpu_reset = 1'b1;
        src_i = '0;
        idle();
        model_reset();
        test_reset();
        test_periodic();
        test_oneshot();
        test_external();
        test_collision();
        test_atomic();
        test_reset_src_high();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_timer_ctrl.md
Name: irq_timer_ctrl

Overview:
- Memory-mapped interrupt controller and programmable interval timer on the MC6809 CPU bus.
- Sits directly upstream of the CPU core and drives its cpu_irq_n and cpu_firq_n inputs, which are currently tied off at the top level.
- Decoded by the top level at one 8-byte window: chip select plus addr[2:0].
- Sources: one internal 16-bit timer plus NSRC external edge-triggered lines (e.g. VGA vsync).

Parameters:
- NSRC, 3, number of external interrupt sources (1..7); pending bit 0 is the timer, bits NSRC:1 are the external sources.
- PRESCALE, 40, cpu_clk cycles per timer tick (>=1).

Ports:
- cpu_clk  input  1  CPU clock; all state on its rising edge.
- cpu_reset  input  1  asynchronous, active-high reset.
- cs_i  input  1  register window selected.
- addr_i  input  3  register index.
- oe_i  input  1  CPU read strobe (cpu_oe_o).
- we_i  input  1  CPU write strobe (cpu_we_o).
- data_i  input  8  CPU write data.
- data_o  output  8  read data; 8'h00 when not (cs_i & oe_i).
- src_i  input  NSRC  external interrupt lines; asynchronous to cpu_clk.
- irq_n_o  output  1  active-low IRQ to the CPU.
- firq_n_o  output  1  active-low FIRQ to the CPU.

Behaviour:
- Registers (r = read, w = write):
  - 0 PEND: r pending[7:0]; w 1-to-clear.
  - 1 MASK: r/w enable bits.
  - 2 ROUTE: r/w; bit set routes the source to FIRQ, clear routes it to IRQ.
  - 3 CTRL: r/w; bit0 EN (timer run), bit1 ONESHOT.
  - 4 RLD_HI: r/w reload[15:8].
  - 5 RLD_LO: r/w reload[7:0]; a write also loads count <= {RLD_HI, data_i}, clears the prescaler, and does not touch EN.
  - 6 CNT_HI: r count[15:8]; the read also snapshots count[7:0] into a shadow register.
  - 7 CNT_LO: r shadow, giving an atomic 16-bit read when HI is read first.
  - Writes to 6 and 7 are ignored.
- A write occurs on every cpu_clk edge where cs_i & we_i are high. Read data is combinational from the current register state.
- Reset values:
  - pending, mask, route, CTRL, reload, count, shadow and prescaler all 0.
  - Synchronizer and edge-history flops 0.
  - irq_n_o = 1, firq_n_o = 1.
- External sources:
  - Two-flop synchronizer, then rising-edge detect: set pending[i+1] one cycle after the second flop rises.
  - Total latency from src_i rising to pending visible is 3 cycles.
  - Levels never re-trigger.
- Timer:
  - Prescaler counts 0..PRESCALE-1 while EN=1 and emits a 1-cycle tick at wrap. It holds at 0 while EN=0.
  - On tick with count != 0: count decrements.
  - On tick with count == 0:
    - pending[0] is set.
    - count reloads from reload.
    - If ONESHOT=1, EN clears on the same edge.
  - reload = 0 with EN=1: pending[0] is set on every tick.
- Simultaneous events:
  - Hardware set and software clear of the same pending bit in one cycle: set wins.
  - CPU write to CTRL or RLD_LO on the same edge as a tick: the CPU write wins and the tick's decrement or reload is discarded. pending[0] is still set if count was 0.
- Outputs are registered with 1-cycle latency after the pending/mask/route update:
  - irq_n_o <= ~|(pending & mask & ~route)
  - firq_n_o <= ~|(pending & mask & route)
  - Bits above NSRC in pending/mask/route are tied 0 and read as 0.
- Reset mid-operation: all state clears immediately (asynchronous reset) and both outputs deassert high. After release, no interrupt is generated from a src_i that is already high until it falls and rises again, because the edge history resets to 0 and the synchronizer refills.

Decomposition:
- Shared package holds:
  - Register index constants: REG_PEND, REG_MASK, REG_ROUTE, REG_CTRL, REG_RLD_HI, REG_RLD_LO, REG_CNT_HI, REG_CNT_LO.
  - CTRL bit positions: CTRL_EN = 0, CTRL_ONESHOT = 1.
- One sub-module: irq_prescale_timer, containing the prescaler, the 16-bit down counter, reload and one-shot logic. Its outputs are count and a 1-cycle expire pulse.

Test Plan:
1. Reset → irq_n_o = 1, firq_n_o = 1; all eight registers read 8'h00.
2. Periodic timer (PRESCALE = 4): write MASK = 8'h01, RLD_HI = 0, RLD_LO = 2, CTRL = 8'h01 → first tick at cycle 4 after the CTRL write; pending[0] set on the 3rd tick (12 cycles after the CTRL write); irq_n_o low 1 cycle later. Write PEND = 8'h01 → irq_n_o high next cycle. Next expiry 12 cycles after the previous one.
3. One-shot: same as scenario 2 with CTRL = 8'h03 → one expiry, then CTRL reads 8'h02 and count holds at reload 2.
4. External edge: MASK = 8'h02, ROUTE = 8'h02, pulse src_i[0] high → pending = 8'h02 after 3 cycles; firq_n_o low the cycle after that; irq_n_o stays 1. Holding src_i high after clearing PEND → no re-assert.
5. Set/clear collision: write PEND = 8'h01 on the same edge as a timer expiry → pending[0] stays 1.
6. Atomic count read: count = 16'h0100 with the next tick decrementing it between the HI and LO reads → HI = 8'h01, LO = 8'h00, taken from the shadow and not from the live value 8'hFF.
